// File: rtl/gfx_pkg.sv
// Shared types and constants for the sprite compositor.
// Contents: table entry structs, layer type codes, ring radii, a span-test helper.
package gfx_pkg;

  localparam int unsigned GFX_COORD_W = 10;
  localparam int unsigned GFX_ADDR_W  = 19;
  localparam int unsigned GFX_TYPE_W  = 8;

  localparam logic [GFX_TYPE_W-1:0] BG_TYPE     = 8'h00;
  localparam logic [GFX_TYPE_W-1:0] RING_A_TYPE = 8'h30;
  localparam logic [GFX_TYPE_W-1:0] RING_B_TYPE = 8'h31;

  localparam int unsigned R_OUT = 70;
  localparam int unsigned R_MID = 60;
  localparam int unsigned R_IN  = 40;

  typedef struct packed {
    logic                   enable;
    logic                   blink;
    logic [GFX_COORD_W-1:0] x;
    logic [GFX_COORD_W-1:0] y;
    logic [GFX_COORD_W-1:0] w;
    logic [GFX_COORD_W-1:0] h;
    logic [GFX_ADDR_W-1:0]  base;
    logic [GFX_TYPE_W-1:0]  typ;
  } sprite_entry_t;

  typedef struct packed {
    logic                   enable;
    logic [GFX_COORD_W-1:0] x;
    logic [GFX_COORD_W-1:0] y;
  } ring_entry_t;

  // lo <= p < lo+len, evaluated one bit wider so lo+len cannot wrap.
  function automatic logic in_span(logic [GFX_COORD_W-1:0] p, logic [GFX_COORD_W-1:0] lo,
                                   logic [GFX_COORD_W-1:0] len);
    logic [GFX_COORD_W:0] pe, le, he;
    pe = {1'b0, p};
    le = {1'b0, lo};
    he = le + {1'b0, len};
    return (pe >= le) && (pe < he);
  endfunction

endpackage

// File: rtl/ring_hit.sv
// Per-ring distance test, registered (pipeline stage 1).
// Ports: clk, rst_n (sync active-low), draw_x/draw_y pixel, cx/cy ring centre,
//        enable (ring enabled and rings drawn), phase (blink phase),
//        hit_outer/hit_inner registered band hits.
module ring_hit
  import gfx_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [GFX_COORD_W-1:0] draw_x,
  input  logic [GFX_COORD_W-1:0] draw_y,
  input  logic [GFX_COORD_W-1:0] cx,
  input  logic [GFX_COORD_W-1:0] cy,
  input  logic                   enable,
  input  logic                   phase,
  output logic                   hit_outer,
  output logic                   hit_inner
);

  localparam int unsigned DW = GFX_COORD_W + 1;
  localparam int unsigned SW = 2 * DW;
  localparam logic [SW-1:0] ROut2 = SW'(R_OUT * R_OUT);
  localparam logic [SW-1:0] RMid2 = SW'(R_MID * R_MID);
  localparam logic [SW-1:0] RIn2  = SW'(R_IN * R_IN);

  logic signed [SW-1:0] dx, dy;
  logic [SW-1:0]        d2;

  always_comb begin
    dx = SW'($signed({1'b0, draw_x}) - $signed({1'b0, cx}));
    dy = SW'($signed({1'b0, draw_y}) - $signed({1'b0, cy}));
    d2 = $unsigned(dx * dx + dy * dy);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_outer <= 1'b0;
      hit_inner <= 1'b0;
    end else begin
      hit_outer <= enable && phase && (d2 >= RMid2) && (d2 <= ROut2);
      hit_inner <= enable && !phase && (d2 >= RIn2) && (d2 < RMid2);
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage per-pixel layer selector: rings > sprites > background.
// Config writes land in a shadow table that is copied to the active table on
// frame_start. Outputs display_type/read_address/pix_valid lag inputs by 2 cycles.
// Ports: Clk, Reset_n (sync active-low), DrawX/DrawY/pix_in pixel stream,
//        frame_start, game_mode, cfg_* valid/ready write port, outputs.
module sprite_compositor
  import gfx_pkg::*;
#(
  parameter  int unsigned NUM_SPRITES  = 8,
  parameter  int unsigned NUM_RINGS    = 8,
  parameter  int unsigned H_RES        = 640,
  parameter  int unsigned BLINK_FRAMES = 30,
  localparam int unsigned COORD_W      = GFX_COORD_W,
  localparam int unsigned ADDR_W       = GFX_ADDR_W,
  localparam int unsigned TYPE_W       = GFX_TYPE_W,
  localparam int unsigned MAX_SLOTS    = (NUM_SPRITES > NUM_RINGS) ? NUM_SPRITES : NUM_RINGS,
  localparam int unsigned IDX_W        = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               pix_in,
  input  logic               frame_start,
  input  logic               game_mode,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_is_ring,
  input  logic [IDX_W-1:0]   cfg_index,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_w,
  input  logic [COORD_W-1:0] cfg_h,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [TYPE_W-1:0]  cfg_type,
  input  logic               cfg_enable,
  input  logic               cfg_blink,
  output logic [TYPE_W-1:0]  display_type,
  output logic [ADDR_W-1:0]  read_address,
  output logic               pix_valid
);

  localparam int unsigned CNT_W = $clog2(2 * BLINK_FRAMES);

  sprite_entry_t    spr_shadow_q  [NUM_SPRITES];
  sprite_entry_t    spr_active_q  [NUM_SPRITES];
  ring_entry_t      ring_shadow_q [NUM_RINGS];
  ring_entry_t      ring_active_q [NUM_RINGS];
  logic [CNT_W-1:0] frame_cnt_q;
  logic             ready_q;
  logic             phase;
  logic             cfg_accept;

  // Writes are refused during the commit cycle so shadow and active never race.
  assign cfg_ready  = ready_q & ~frame_start;
  assign cfg_accept = cfg_valid & cfg_ready;
  assign phase      = (frame_cnt_q < CNT_W'(BLINK_FRAMES));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ready_q     <= 1'b0;
      frame_cnt_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        spr_shadow_q[i] <= '0;
        spr_active_q[i] <= '0;
      end
      for (int i = 0; i < NUM_RINGS; i++) begin
        ring_shadow_q[i] <= '0;
        ring_active_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (cfg_accept) begin
        // Out-of-range indices are accepted but dropped.
        if (cfg_is_ring) begin
          if (32'(cfg_index) < NUM_RINGS) begin
            ring_shadow_q[cfg_index] <= '{enable: cfg_enable, x: cfg_x, y: cfg_y};
          end
        end else if (32'(cfg_index) < NUM_SPRITES) begin
          spr_shadow_q[cfg_index] <= '{enable: cfg_enable, blink: cfg_blink, x: cfg_x,
                                       y: cfg_y, w: cfg_w, h: cfg_h, base: cfg_base,
                                       typ: cfg_type};
        end
      end
      if (frame_start) begin
        spr_active_q  <= spr_shadow_q;
        ring_active_q <= ring_shadow_q;
        frame_cnt_q   <= (frame_cnt_q == CNT_W'(2 * BLINK_FRAMES - 1)) ? '0
                                                                     : frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1: sprite hits. The winning sprite's offsets and attributes are captured here
  // so a commit landing mid-line cannot mix old hits with new table contents in stage 2.
  logic [NUM_SPRITES-1:0] spr_hit;
  logic [COORD_W-1:0]     sel_off_x, sel_off_y, sel_w;
  logic [ADDR_W-1:0]      sel_base;
  logic [TYPE_W-1:0]      sel_type;

  always_comb begin
    spr_hit   = '0;
    sel_off_x = '0;
    sel_off_y = '0;
    sel_w     = '0;
    sel_base  = '0;
    sel_type  = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      spr_hit[i] = spr_active_q[i].enable && (!spr_active_q[i].blink || phase) &&
                   in_span(DrawX, spr_active_q[i].x, spr_active_q[i].w) &&
                   in_span(DrawY, spr_active_q[i].y, spr_active_q[i].h);
    end
    // Walk from lowest priority up so the lowest index is the final assignment.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (spr_hit[i]) begin
        sel_off_x = DrawX - spr_active_q[i].x;
        sel_off_y = DrawY - spr_active_q[i].y;
        sel_w     = spr_active_q[i].w;
        sel_base  = spr_active_q[i].base;
        sel_type  = spr_active_q[i].typ;
      end
    end
  end

  logic [NUM_SPRITES-1:0] s1_spr_hit_q;
  logic [COORD_W-1:0]     s1_off_x_q, s1_off_y_q, s1_w_q, s1_x_q, s1_y_q;
  logic [ADDR_W-1:0]      s1_base_q;
  logic [TYPE_W-1:0]      s1_type_q;
  logic                   s1_pix_q;
  logic [NUM_RINGS-1:0]   ring_outer, ring_inner;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_spr_hit_q <= '0;
      s1_off_x_q   <= '0;
      s1_off_y_q   <= '0;
      s1_w_q       <= '0;
      s1_base_q    <= '0;
      s1_type_q    <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_pix_q     <= 1'b0;
    end else begin
      s1_spr_hit_q <= spr_hit;
      s1_off_x_q   <= sel_off_x;
      s1_off_y_q   <= sel_off_y;
      s1_w_q       <= sel_w;
      s1_base_q    <= sel_base;
      s1_type_q    <= sel_type;
      s1_x_q       <= DrawX;
      s1_y_q       <= DrawY;
      s1_pix_q     <= pix_in;
    end
  end

  for (genvar g = 0; g < NUM_RINGS; g++) begin : g_ring
    ring_hit u_ring_hit (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .draw_x    (DrawX),
      .draw_y    (DrawY),
      .cx        (ring_active_q[g].x),
      .cy        (ring_active_q[g].y),
      .enable    (ring_active_q[g].enable & game_mode),
      .phase     (phase),
      .hit_outer (ring_outer[g]),
      .hit_inner (ring_inner[g])
    );
  end

  // Stage 2: final priority and address arithmetic.
  logic [TYPE_W-1:0] out_type;
  logic [ADDR_W-1:0] out_addr;

  always_comb begin
    out_type = BG_TYPE;
    out_addr = ADDR_W'(s1_y_q) * ADDR_W'(H_RES) + ADDR_W'(s1_x_q);
    if (|s1_spr_hit_q) begin
      out_type = s1_type_q;
      out_addr = s1_base_q + ADDR_W'(s1_off_y_q) * ADDR_W'(s1_w_q) + ADDR_W'(s1_off_x_q);
    end
    for (int i = NUM_RINGS - 1; i >= 0; i--) begin
      if (ring_outer[i] || ring_inner[i]) begin
        out_type = ring_outer[i] ? RING_A_TYPE : RING_B_TYPE;
        out_addr = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      display_type <= '0;
      read_address <= '0;
      pix_valid    <= 1'b0;
    end else begin
      display_type <= out_type;
      read_address <= out_addr;
      pix_valid    <= s1_pix_q;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
module tb_sprite_compositor;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n, pix_in, frame_start, game_mode;
  logic [9:0]  DrawX, DrawY;
  logic        cfg_valid, cfg_ready, cfg_is_ring, cfg_enable, cfg_blink;
  logic [2:0]  cfg_index;
  logic [9:0]  cfg_x, cfg_y, cfg_w, cfg_h;
  logic [18:0] cfg_base;
  logic [7:0]  cfg_type;
  logic [7:0]  display_type;
  logic [18:0] read_address;
  logic        pix_valid;

  sprite_compositor dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .pix_in       (pix_in),
    .frame_start  (frame_start),
    .game_mode    (game_mode),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_is_ring  (cfg_is_ring),
    .cfg_index    (cfg_index),
    .cfg_x        (cfg_x),
    .cfg_y        (cfg_y),
    .cfg_w        (cfg_w),
    .cfg_h        (cfg_h),
    .cfg_base     (cfg_base),
    .cfg_type     (cfg_type),
    .cfg_enable   (cfg_enable),
    .cfg_blink    (cfg_blink),
    .display_type (display_type),
    .read_address (read_address),
    .pix_valid    (pix_valid)
  );

  // Behavioural reference state.
  typedef struct {int en; int bl; int x; int y; int w; int h; int base; int typ;} spr_m_t;
  typedef struct {int en; int x; int y;} ring_m_t;
  typedef struct {bit v; int t; int a;} pe_t;
  typedef struct {int x; int y; int t; int a;} vec_t;

  spr_m_t  sh_s [8];
  spr_m_t  ac_s [8];
  ring_m_t sh_r [8];
  ring_m_t ac_r [8];
  int      m_fc;
  bit      m_ready, m_known, m_last_acc;
  pe_t     m_s1, m_out;
  int      n_cmp, n_bad;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Layer choice from the rules: first matching ring, else first matching sprite,
  // else background.
  function automatic void ref_pixel(input int px, input int py, input bit gm,
                                    output int t, output int a);
    bit ph = (m_fc < 30);
    bit found = 0;
    if (gm) begin
      for (int i = 0; i < 8 && !found; i++) begin
        if (ac_r[i].en != 0) begin
          int dx = px - ac_r[i].x;
          int dy = py - ac_r[i].y;
          int d2 = dx * dx + dy * dy;
          if (ph && d2 >= 60 * 60 && d2 <= 70 * 70) begin
            t = 'h30; a = 0; found = 1;
          end else if (!ph && d2 >= 40 * 40 && d2 < 60 * 60) begin
            t = 'h31; a = 0; found = 1;
          end
        end
      end
    end
    for (int i = 0; i < 8 && !found; i++) begin
      spr_m_t s = ac_s[i];
      if (s.en != 0 && (s.bl == 0 || ph) && px >= s.x && px < s.x + s.w &&
          py >= s.y && py < s.y + s.h) begin
        t = s.typ;
        a = (s.base + (py - s.y) * s.w + (px - s.x)) % 524288;
        found = 1;
      end
    end
    if (!found) begin
      t = 0;
      a = (py * 640 + px) % 524288;
    end
  endfunction

  // One clock: check the combinational ready, advance model and DUT, compare outputs.
  task automatic step();
    pe_t e;
    bit  acc;
    bit  rst_edge;
    #1;
    if (m_known) check("cfg_ready", {31'b0, cfg_ready}, {31'b0, m_ready && !frame_start});
    e.v = pix_in;
    ref_pixel(int'(DrawX), int'(DrawY), game_mode, e.t, e.a);
    acc = cfg_valid && m_ready && !frame_start;
    @(posedge Clk);
    rst_edge = !Reset_n;
    if (rst_edge) begin
      for (int i = 0; i < 8; i++) begin
        sh_s[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
        ac_s[i] = sh_s[i];
        sh_r[i] = '{0, 0, 0};
        ac_r[i] = sh_r[i];
      end
      m_fc = 0; m_ready = 0; m_known = 1; m_last_acc = 0;
      m_s1 = '{0, 0, 0};
      m_out = '{0, 0, 0};
    end else begin
      m_last_acc = acc;
      if (acc) begin
        if (cfg_is_ring)
          sh_r[cfg_index] = '{int'(cfg_enable), int'(cfg_x), int'(cfg_y)};
        else
          sh_s[cfg_index] = '{int'(cfg_enable), int'(cfg_blink), int'(cfg_x), int'(cfg_y),
                              int'(cfg_w), int'(cfg_h), int'(cfg_base), int'(cfg_type)};
      end
      if (frame_start) begin
        ac_s = sh_s;
        ac_r = sh_r;
        m_fc = (m_fc + 1) % 60;
      end
      m_ready = 1;
      m_out = m_s1;
      m_s1 = e;
    end
    #1;
    if (m_known) begin
      check("pix_valid", {31'b0, pix_valid}, {31'b0, m_out.v});
      if (m_out.v || rst_edge) begin
        check("model_type", 32'(display_type), m_out.t);
        check("model_addr", 32'(read_address), m_out.a);
      end
    end
  endtask

  task automatic probe(input int x, input int y, input bit gm, input int et, input int ea,
                       input string nm);
    DrawX = 10'(x); DrawY = 10'(y); game_mode = gm; pix_in = 1'b1;
    step();
    pix_in = 1'b0;
    step();
    check({nm, "_type"}, 32'(display_type), et);
    check({nm, "_addr"}, 32'(read_address), ea);
  endtask

  task automatic cfg_write(input bit ring, input int idx, input int x, input int y,
                           input int w, input int h, input int base, input int typ,
                           input bit en, input bit bl);
    bit got = 0;
    cfg_is_ring = ring; cfg_index = 3'(idx); cfg_x = 10'(x); cfg_y = 10'(y);
    cfg_w = 10'(w); cfg_h = 10'(h); cfg_base = 19'(base); cfg_type = 8'(typ);
    cfg_enable = en; cfg_blink = bl; cfg_valid = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      step();
      got = m_last_acc;
    end
    cfg_valid = 1'b0;
    check("cfg_write_accepted", {31'b0, got}, 32'd1);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  vec_t vecs [11];

  initial begin
    n_cmp = 0; n_bad = 0;
    m_fc = 0; m_ready = 0; m_known = 0; m_last_acc = 0;
    m_s1 = '{0, 0, 0}; m_out = '{0, 0, 0};
    Reset_n = 1'b0; pix_in = 1'b0; frame_start = 1'b0; game_mode = 1'b0;
    DrawX = '0; DrawY = '0; cfg_valid = 1'b0; cfg_is_ring = 1'b0; cfg_index = '0;
    cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_base = '0; cfg_type = '0;
    cfg_enable = 1'b0; cfg_blink = 1'b0;

    vecs = '{'{122, 72, 'h04, 1012},     '{100, 50, 'h04, 0},
             '{144, 94, 'h04, 2024},     '{145, 72, 'h00, 46225},
             '{122, 95, 'h00, 60922},    '{99, 50, 'h00, 32099},
             '{200, 200, 'h07, 5820},    '{219, 219, 'h07, 6599},
             '{220, 200, 'h00, 128220},  '{1020, 910, 'h55, 504},
             '{1023, 949, 'h55, 2457}};

    // Reset state.
    step();
    step();
    check("rst_type", 32'(display_type), 0);
    check("rst_addr", 32'(read_address), 0);
    check("rst_pix_valid", {31'b0, pix_valid}, 0);
    check("rst_cfg_ready", {31'b0, cfg_ready}, 0);
    Reset_n = 1'b1;
    step();
    check("ready_after_release", {31'b0, cfg_ready}, 1);

    // Writes stay in shadow until a commit.
    cfg_write(0, 0, 100, 50, 45, 45, 0, 'h04, 1, 0);
    cfg_write(0, 3, 180, 180, 40, 40, 5000, 'h07, 1, 0);
    cfg_write(0, 5, 1000, 900, 50, 50, 'h7FFF0, 'h55, 1, 0);
    probe(122, 72, 0, 0, 46202, "no_commit");
    frame_pulse();
    for (int i = 0; i < 11; i++) probe(vecs[i].x, vecs[i].y, 0, vecs[i].t, vecs[i].a,
                                       $sformatf("tbl%0d", i));
    probe(1023, 950, 0, 0, 84735, "wrap_below");

    // Overlap priority, then disable the winner.
    cfg_write(0, 0, 190, 190, 20, 20, 100, 'h04, 1, 0);
    frame_pulse();
    probe(200, 200, 0, 'h04, 310, "overlap_s0");
    probe(215, 215, 0, 'h07, 6435, "overlap_s3_only");
    cfg_write(0, 0, 190, 190, 20, 20, 100, 'h04, 0, 0);
    frame_pulse();
    probe(200, 200, 0, 'h07, 5820, "overlap_s0_off");

    // Write held across a commit cycle.
    cfg_is_ring = 1'b0; cfg_index = 3'd2; cfg_x = 10'd300; cfg_y = 10'd300;
    cfg_w = 10'd10; cfg_h = 10'd10; cfg_base = 19'd7; cfg_type = 8'h22;
    cfg_enable = 1'b1; cfg_blink = 1'b0; cfg_valid = 1'b1; frame_start = 1'b1;
    #1;
    check("ready_low_in_commit", {31'b0, cfg_ready}, 0);
    step();
    frame_start = 1'b0;
    step();
    cfg_valid = 1'b0;
    probe(305, 305, 0, 0, 195505, "cross_not_yet");
    frame_pulse();
    probe(305, 305, 0, 'h22, 62, "cross_committed");

    // Reset in the middle of a line.
    pix_in = 1'b1; DrawY = 10'd305;
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'(300 + i);
      step();
    end
    Reset_n = 1'b0;
    step();
    check("midrst_type", 32'(display_type), 0);
    check("midrst_addr", 32'(read_address), 0);
    check("midrst_pix_valid", {31'b0, pix_valid}, 0);
    check("midrst_cfg_ready", {31'b0, cfg_ready}, 0);
    Reset_n = 1'b1; DrawX = 10'd305;
    step();
    check("midrst_lat1_pix_valid", {31'b0, pix_valid}, 0);
    DrawX = 10'd306;
    step();
    check("midrst_lat2_pix_valid", {31'b0, pix_valid}, 1);
    check("midrst_lat2_type", 32'(display_type), 0);
    check("midrst_lat2_addr", 32'(read_address), 195505);
    pix_in = 1'b0;

    // Blinking ring bands (frame counter restarted by the reset above).
    cfg_write(1, 0, 155, 402, 0, 0, 0, 0, 1, 0);
    frame_pulse();
    probe(220, 402, 1, 'h30, 0, "ringA_ph1");
    probe(205, 402, 1, 0, 257485, "ringB_off_ph1");
    probe(220, 402, 0, 0, 257500, "ring_gm0");
    repeat (29) frame_pulse();
    probe(220, 402, 1, 0, 257500, "ringA_off_ph0");
    probe(205, 402, 1, 'h31, 0, "ringB_ph0");
    repeat (30) frame_pulse();
    probe(220, 402, 1, 'h30, 0, "ringA_wrap");

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      Reset_n     = ($urandom_range(0, 599) != 0);
      frame_start = ($urandom_range(0, 9) == 0);
      game_mode   = ($urandom_range(0, 3) != 0);
      pix_in      = ($urandom_range(0, 4) != 0);
      DrawX       = 10'($urandom_range(0, 330));
      DrawY       = 10'($urandom_range(0, 330));
      cfg_valid   = ($urandom_range(0, 3) == 0);
      cfg_is_ring = ($urandom_range(0, 2) == 0);
      cfg_index   = 3'($urandom_range(0, 7));
      cfg_x       = 10'($urandom_range(0, 255));
      cfg_y       = 10'($urandom_range(0, 255));
      cfg_w       = 10'($urandom_range(0, 80));
      cfg_h       = 10'($urandom_range(0, 80));
      cfg_base    = 19'($urandom);
      cfg_type    = 8'($urandom);
      cfg_enable  = ($urandom_range(0, 3) != 0);
      cfg_blink   = ($urandom_range(0, 1) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
